// File: rtl/capture_sequencer.sv
// rtl/capture_sequencer.sv - single-word capture sequencer with setup/hold phasing and sticky hold-violation flag
module capture_sequencer #(
    parameter int WIDTH  = 8,
    parameter int TSETUP = 2,
    parameter int THOLD  = 1,
    parameter int CNT_W  = 4
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             req,
    input  logic [WIDTH-1:0] V,
    input  logic             err_clr,
    output logic             busy,
    output logic             cap_en,
    output logic [WIDTH-1:0] W,
    output logic             Q,
    output logic             Qb,
    output logic             ack,
    output logic             Err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_CAPTURE,
        S_HOLD,
        S_DONE
    } state_t;

    localparam logic [CNT_W-1:0] SETUP_LOAD = CNT_W'(TSETUP - 1);
    localparam logic [CNT_W-1:0] HOLD_LOAD  = CNT_W'((THOLD > 0) ? THOLD - 1 : 0);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   d_lat_q, d_lat_d;
    logic [WIDTH-1:0]   w_q, w_d;
    logic               busy_q, busy_d;
    logic               q_q, q_d;
    logic               qb_q, qb_d;
    logic               err_q, err_d;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        d_lat_d = d_lat_q;
        w_d     = w_q;
        busy_d  = busy_q;
        q_d     = q_q;
        qb_d    = qb_q;
        // A violation in the same cycle as a clear must leave the flag set.
        err_d   = err_q & ~err_clr;
        case (state_q)
            S_IDLE: begin
                if (req) begin
                    d_lat_d = V;
                    busy_d  = 1'b1;
                    cnt_d   = SETUP_LOAD;
                    state_d = S_SETUP;
                end
            end
            S_SETUP: begin
                if (!req) begin
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = S_IDLE;
                end else if (cnt_q == '0) begin
                    state_d = S_CAPTURE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_CAPTURE: begin
                w_d  = d_lat_q;
                q_d  = ^d_lat_q;
                qb_d = ~(^d_lat_q);
                if (THOLD > 0) begin
                    cnt_d   = HOLD_LOAD;
                    state_d = S_HOLD;
                end else begin
                    state_d = S_DONE;
                end
            end
            S_HOLD: begin
                if (!req || (V != d_lat_q)) begin
                    err_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_DONE: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            d_lat_q <= '0;
            w_q     <= '0;
            busy_q  <= 1'b0;
            q_q     <= 1'b0;
            qb_q    <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            d_lat_q <= d_lat_d;
            w_q     <= w_d;
            busy_q  <= busy_d;
            q_q     <= q_d;
            qb_q    <= qb_d;
            err_q   <= err_d;
        end
    end

    assign cap_en = (state_q == S_CAPTURE);
    assign ack    = (state_q == S_DONE);
    assign busy   = busy_q;
    assign W      = w_q;
    assign Q      = q_q;
    assign Qb     = qb_q;
    assign Err    = err_q;

endmodule

// File: tb/tb_capture_sequencer.sv
// tb/tb_capture_sequencer.sv - scoreboard bench for capture_sequencer (THOLD=1 and THOLD=0 builds)
module tb_capture_sequencer;

    logic       clk;
    logic       rst_n;
    logic       req, err_clr;
    logic [7:0] v;
    logic       busy, cap_en, q, qb, ack, err;
    logic [7:0] w;

    logic       req2, err_clr2;
    logic [7:0] v2;
    logic       busy2, cap_en2, q2, qb2, ack2, err2;
    logic [7:0] w2;

    int         checks = 0;
    int         errors = 0;
    logic       err_model = 1'b0;
    logic [7:0] sb[$];
    logic [7:0] e;

    capture_sequencer #(.WIDTH(8), .TSETUP(2), .THOLD(1), .CNT_W(4)) dut (
        .Clk(clk), .Rst(rst_n), .req(req), .V(v), .err_clr(err_clr),
        .busy(busy), .cap_en(cap_en), .W(w), .Q(q), .Qb(qb), .ack(ack), .Err(err)
    );

    capture_sequencer #(.WIDTH(8), .TSETUP(2), .THOLD(0), .CNT_W(4)) dut0 (
        .Clk(clk), .Rst(rst_n), .req(req2), .V(v2), .err_clr(err_clr2),
        .busy(busy2), .cap_en(cap_en2), .W(w2), .Q(q2), .Qb(qb2), .ack(ack2), .Err(err2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic pop_and_check(input logic [7:0] aw, input logic aq, input logic aqb, input string tag);
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s scoreboard empty at ack", tag);
        end else begin
            e = sb.pop_front();
            if (aw !== e) begin errors++; $display("FAIL %s W got %0h exp %0h", tag, aw, e); end
            checks++;
            if (aq !== ^e) begin errors++; $display("FAIL %s Q got %0b exp %0b", tag, aq, ^e); end
            checks++;
            if (aqb !== ~(^e)) begin errors++; $display("FAIL %s Qb got %0b exp %0b", tag, aqb, ~(^e)); end
        end
    endtask

    // One full request: v at accept, v_hold driven into the HOLD cycle, optional err_clr there.
    task automatic run_seq(input logic [7:0] vin, input logic [7:0] v_hold, input logic clr_in_hold, input string tag);
        logic exp_err_end;
        exp_err_end = (v_hold != vin) ? 1'b1 : (clr_in_hold ? 1'b0 : err_model);
        @(negedge clk);
        req = 1'b1; v = vin; sb.push_back(vin);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL %s busy c%0d got %0b exp 1", tag, c, busy); end
            checks++;
            if (cap_en !== (c == 3)) begin errors++; $display("FAIL %s cap_en c%0d got %0b exp %0b", tag, c, cap_en, c == 3); end
            checks++;
            if (ack !== (c == 5)) begin errors++; $display("FAIL %s ack c%0d got %0b exp %0b", tag, c, ack, c == 5); end
            checks++;
            if (err !== ((c == 5) ? exp_err_end : err_model)) begin
                errors++;
                $display("FAIL %s Err c%0d got %0b exp %0b", tag, c, err, (c == 5) ? exp_err_end : err_model);
            end
            if (c == 4) begin v = v_hold; err_clr = clr_in_hold; end
            if (c == 5) begin
                pop_and_check(w, q, qb, tag);
                err_clr = 1'b0; req = 1'b0;
            end
        end
        err_model = exp_err_end;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || ack !== 1'b0) begin errors++; $display("FAIL %s idle busy/ack got %0b/%0b exp 0/0", tag, busy, ack); end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; req = 1'b0; v = 8'h00; err_clr = 1'b0;
        req2 = 1'b0; v2 = 8'h00; err_clr2 = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({w, q, qb, busy, cap_en, ack, err} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset W=%0h Q=%0b Qb=%0b busy=%0b cap=%0b ack=%0b Err=%0b exp 0 0 1 0 0 0 0", w, q, qb, busy, cap_en, ack, err);
        end
        checks++;
        if ({w2, qb2, busy2, err2} !== {8'h00, 1'b1, 1'b0, 1'b0}) begin
            errors++; $display("FAIL reset0 W=%0h Qb=%0b busy=%0b Err=%0b exp 0 1 0 0", w2, qb2, busy2, err2);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_basic;
        run_seq(8'hA5, 8'hA5, 1'b0, "basic_a5");
    endtask

    task automatic test_parity;
        run_seq(8'h01, 8'h01, 1'b0, "parity_01");
        run_seq(8'hFF, 8'hFF, 1'b0, "parity_ff");
    endtask

    task automatic test_abort;
        @(negedge clk);
        req = 1'b1; v = 8'h77;
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            if (c <= 2) begin
                checks++;
                if (busy !== 1'b1) begin errors++; $display("FAIL abort busy c%0d got %0b exp 1", c, busy); end
                if (c == 2) req = 1'b0;
            end else begin
                checks++;
                if (busy !== 1'b0 || cap_en !== 1'b0 || ack !== 1'b0) begin
                    errors++; $display("FAIL abort c%0d busy/cap/ack got %0b/%0b/%0b exp 0/0/0", c, busy, cap_en, ack);
                end
                checks++;
                if (w !== 8'hFF || err !== err_model) begin
                    errors++; $display("FAIL abort c%0d W/Err got %0h/%0b exp ff/%0b", c, w, err, err_model);
                end
            end
        end
    endtask

    task automatic test_hold_violation;
        run_seq(8'h3C, 8'h00, 1'b0, "hold_viol");
        @(negedge clk); err_clr = 1'b1;
        @(negedge clk); err_clr = 1'b0;
        err_model = 1'b0;
        checks++;
        if (err !== 1'b0) begin errors++; $display("FAIL err_clr Err got %0b exp 0", err); end
        checks++;
        if (w !== 8'h3C) begin errors++; $display("FAIL err_clr W got %0h exp 3c", w); end
    endtask

    task automatic test_set_clear_same;
        run_seq(8'h5A, 8'h00, 1'b1, "set_clr_same");
    endtask

    task automatic test_thold0;
        @(negedge clk);
        req2 = 1'b1; v2 = 8'hC3; sb.push_back(8'hC3);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (cap_en2 !== (c == 3)) begin errors++; $display("FAIL th0 cap_en c%0d got %0b exp %0b", c, cap_en2, c == 3); end
            checks++;
            if (ack2 !== (c == 4)) begin errors++; $display("FAIL th0 ack c%0d got %0b exp %0b", c, ack2, c == 4); end
            checks++;
            if (busy2 !== (c <= 4)) begin errors++; $display("FAIL th0 busy c%0d got %0b exp %0b", c, busy2, c <= 4); end
            checks++;
            if (err2 !== 1'b0) begin errors++; $display("FAIL th0 Err c%0d got %0b exp 0", c, err2); end
            if (c == 3) v2 = 8'h00;
            if (c == 4) begin
                pop_and_check(w2, q2, qb2, "th0");
                req2 = 1'b0;
            end
        end
    endtask

    task automatic test_reset_mid;
        @(negedge clk);
        req = 1'b1; v = 8'hE7;
        repeat (3) @(negedge clk);
        checks++;
        if (cap_en !== 1'b1) begin errors++; $display("FAIL rst_mid cap_en got %0b exp 1", cap_en); end
        #1 rst_n = 1'b0;
        #1;
        err_model = 1'b0;
        checks++;
        if ({w, q, qb, busy, cap_en, ack, err} !== {8'h00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL rst_mid W=%0h Q=%0b Qb=%0b busy=%0b cap=%0b ack=%0b Err=%0b exp 0 0 1 0 0 0 0", w, q, qb, busy, cap_en, ack, err);
        end
        @(negedge clk);
        rst_n = 1'b1;
        sb.push_back(8'hE7);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b1) begin errors++; $display("FAIL restart busy c%0d got %0b exp 1", c, busy); end
            checks++;
            if (cap_en !== (c == 3) || ack !== (c == 5)) begin
                errors++; $display("FAIL restart c%0d cap/ack got %0b/%0b exp %0b/%0b", c, cap_en, ack, c == 3, c == 5);
            end
            if (c == 5) begin
                pop_and_check(w, q, qb, "restart");
                req = 1'b0;
            end
        end
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL restart idle busy got %0b exp 0", busy); end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_parity;
        test_abort;
        test_hold_violation;
        test_set_clear_same;
        test_thold0;
        test_reset_mid;
        checks++;
        if (sb.size() != 0) begin errors++; $display("FAIL scoreboard leftover got %0d exp 0", sb.size()); end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end

endmodule
